// File: rtl/traffic_pkg.sv
// Shared phase encodings, lamp patterns and the phase successor rule for the
// two-way intersection sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    RED_A = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    RED_B = 3'd6,
    FLASH = 3'd7
  } phase_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Night mode only diverts at all-red (or INIT/FLASH), so a green always
  // passes through yellow and all-red before flashing starts.
  function automatic phase_t next_phase(input phase_t p, input logic night_mode);
    next_phase = FLASH;
    case (p)
      INIT:    next_phase = night_mode ? FLASH : NS_G;
      NS_G:    next_phase = NS_Y;
      NS_Y:    next_phase = RED_A;
      RED_A:   next_phase = night_mode ? FLASH : EW_G;
      EW_G:    next_phase = EW_Y;
      EW_Y:    next_phase = RED_B;
      RED_B:   next_phase = night_mode ? FLASH : NS_G;
      FLASH:   next_phase = night_mode ? FLASH : RED_B;
      default: next_phase = FLASH;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_fsm_phase_lamp_decode.sv
// Combinational lamp decode: current phase plus flash blink state to one-hot
// {R,Y,G} patterns for both roads.
module phase_lamp_decode
  import traffic_pkg::*;
(
  input  traffic_pkg::phase_t phase,
  input  logic                blink,
  output logic [2:0]          ns_lamp,
  output logic [2:0]          ew_lamp
);

  always_comb begin
    ns_lamp = LAMP_R;
    ew_lamp = LAMP_R;
    case (phase)
      NS_G:  ns_lamp = LAMP_G;
      NS_Y:  ns_lamp = LAMP_Y;
      EW_G:  ew_lamp = LAMP_G;
      EW_Y:  ew_lamp = LAMP_Y;
      FLASH: begin
        ns_lamp = blink ? LAMP_Y : LAMP_OFF;
        ew_lamp = blink ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Intersection phase sequencer: advances on countdown expiry and requests the
// countdown reload for the phase that follows the one just entered.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned COUNT_BITS = 8,
  parameter int unsigned GREEN_T    = 25,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALLRED_T   = 2,
  parameter int unsigned FLASH_T    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  night,
  input  logic                  timeout,
  output logic                  start,
  output logic [COUNT_BITS-1:0] count_from,
  output logic [2:0]            phase,
  output logic [2:0]            ns_lamp,
  output logic [2:0]            ew_lamp
);

  if (COUNT_BITS == 0 || GREEN_T == 0 || YELLOW_T == 0 ||
      ALLRED_T == 0 || FLASH_T == 0) begin : g_param_check
    $error("traffic_phase_fsm: parameters must all be >= 1");
  end

  phase_t state;
  phase_t plan;
  logic   night_q;
  logic   blink;
  logic   latch_pend;
  logic   start_pend;
  logic   enable_q;
  logic   adv;

  function automatic logic [COUNT_BITS-1:0] dur_of(input phase_t p);
    dur_of = '0;
    case (p)
      NS_G, EW_G:   dur_of = COUNT_BITS'(GREEN_T - 1);
      NS_Y, EW_Y:   dur_of = COUNT_BITS'(YELLOW_T - 1);
      RED_A, RED_B: dur_of = COUNT_BITS'(ALLRED_T - 1);
      FLASH:        dur_of = COUNT_BITS'(FLASH_T - 1);
      default:      dur_of = '0;
    endcase
  endfunction

  assign adv   = tick & timeout & enable;
  assign plan  = next_phase(state, night_q);
  assign phase = state;

  // Two-step reload pipeline after each boundary: latch night, then request
  // the reload using the plan derived from the freshly latched night level.
  // enable_q resets high so a release with enable already asserted does not
  // count as an enable rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      night_q    <= 1'b0;
      blink      <= 1'b0;
      latch_pend <= 1'b1;
      start_pend <= 1'b0;
      start      <= 1'b0;
      count_from <= '0;
      enable_q   <= 1'b1;
    end else begin
      enable_q <= enable;
      start    <= 1'b0;

      if (latch_pend) begin
        night_q    <= night;
        latch_pend <= 1'b0;
        start_pend <= 1'b1;
      end

      if (start_pend) begin
        start      <= 1'b1;
        count_from <= dur_of(plan);
        start_pend <= 1'b0;
      end else if (enable && !enable_q) begin
        start <= 1'b1;
      end

      if (adv) begin
        state      <= plan;
        latch_pend <= 1'b1;
        if (plan == FLASH) begin
          blink <= (state == FLASH) ? ~blink : 1'b0;
        end
      end
    end
  end

  phase_lamp_decode u_decode (
    .phase   (state),
    .blink   (blink),
    .ns_lamp (ns_lamp),
    .ew_lamp (ew_lamp)
  );

  a_no_double_green : assert property (
    @(posedge clk) disable iff (!rst_n)
    !((ns_lamp == LAMP_G) && (ew_lamp == LAMP_G))
  );

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: drives a reload-on-expiry countdown and checks
// every cycle against a table-driven phase model plus literal spot checks.
module tb_traffic_phase_fsm;

  localparam int G = 5;
  localparam int Y = 2;
  localparam int A = 1;
  localparam int F = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b1;
  logic       night = 1'b0;
  logic       timeout;
  logic       start;
  logic [7:0] count_from;
  logic [2:0] phase, ns_lamp, ew_lamp;
  logic [7:0] cd_count, cd_reload;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_phase_fsm #(
    .COUNT_BITS (8),
    .GREEN_T    (G),
    .YELLOW_T   (Y),
    .ALLRED_T   (A),
    .FLASH_T    (F)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .enable     (enable),
    .night      (night),
    .timeout    (timeout),
    .start      (start),
    .count_from (count_from),
    .phase      (phase),
    .ns_lamp    (ns_lamp),
    .ew_lamp    (ew_lamp)
  );

  // Countdown: start stores the reload value, which is applied when an
  // expired count sees the next tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_count  <= 8'd0;
      cd_reload <= 8'd0;
    end else begin
      if (start && enable) cd_reload <= count_from;
      if (tick && enable) cd_count <= (cd_count == 8'd0) ? cd_reload : cd_count - 8'd1;
    end
  end
  assign timeout = (cd_count == 8'd0);

  int day_next[8]   = '{1, 2, 3, 4, 5, 6, 1, 6};
  int night_next[8] = '{7, 2, 3, 7, 5, 6, 7, 7};
  int dur_tab[8]    = '{0, G-1, Y-1, A-1, G-1, Y-1, A-1, F-1};
  int ns_tab[8]     = '{4, 1, 2, 4, 4, 4, 4, 0};
  int ew_tab[8]     = '{4, 4, 4, 4, 1, 2, 4, 0};

  int m_phase = 0, m_cf = 0, start_at = -1, latch_at = -1, cyc = 0;
  bit m_nq = 0, m_blink = 0, exp_start = 0, m_en = 1;

  int ph_q[$];
  int starts[$];
  int tick_cnt = 0;
  int cur_ph = 0, prev_ph = 0;

  function automatic int nxt(input int p, input bit n);
    return n ? night_next[p] : day_next[p];
  endfunction

  function automatic int lamp_ns(input int p, input bit b);
    return (p == 7) ? (b ? 2 : 0) : ns_tab[p];
  endfunction

  function automatic int lamp_ew(input int p, input bit b);
    return (p == 7) ? (b ? 2 : 0) : ew_tab[p];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cf = 0; start_at = -1; latch_at = -1;
    m_nq = 0; m_blink = 0; exp_start = 0; m_en = 1;
  endtask

  always @(posedge clk) begin
    bit a;
    int nx;
    cyc++;
    if (rst_n) begin
      exp_start = 0;
      a = tick && timeout && enable;
      if (latch_at == cyc) begin
        m_nq = night;
        start_at = cyc + 1;
      end
      if (start_at == cyc) begin
        exp_start = 1;
        m_cf = dur_tab[nxt(m_phase, m_nq)];
      end else if (enable && !m_en) begin
        exp_start = 1;
      end
      if (a) begin
        nx = nxt(m_phase, m_nq);
        if (nx == 7) m_blink = (m_phase == 7) ? !m_blink : 1'b0;
        m_phase = nx;
        latch_at = cyc + 1;
      end
      m_en = enable;
    end
    #1;
    chk("start", int'(start), int'(exp_start));
    chk("count_from", int'(count_from), m_cf);
    chk("phase", int'(phase), m_phase);
    chk("ns_lamp", int'(ns_lamp), lamp_ns(m_phase, m_blink));
    chk("ew_lamp", int'(ew_lamp), lamp_ew(m_phase, m_blink));
    chk("no_double_green", int'(ns_lamp == 3'b001 && ew_lamp == 3'b001), 0);
  end

  task automatic step();
    bit t;
    t = tick && enable;
    @(posedge clk);
    #1;
    if (rst_n && t) ph_q.push_back(int'(phase));
    if (rst_n && start) starts.push_back(int'(count_from));
    if (int'(phase) != cur_ph) begin
      prev_ph = cur_ph;
      cur_ph = int'(phase);
    end
    tick_cnt++;
    tick = (tick_cnt % 8 == 0);
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    latch_at = cyc + 1;
    tick = 1'b0;
    tick_cnt = 0;
    ph_q.delete();
    starts.delete();
  endtask

  task automatic wait_phase(input int p, input int lim, input string name);
    for (int i = 0; i < lim && int'(phase) != p; i++) step();
    chk(name, int'(phase), p);
  endtask

  task automatic wait_start(input int lim, input string name);
    for (int i = 0; i < lim && !start; i++) step();
    chk(name, int'(start), 1);
  endtask

  task automatic next_tick();
    int n;
    n = ph_q.size();
    for (int i = 0; i < 20 && ph_q.size() == n; i++) step();
    chk("tick_seen", ph_q.size(), n + 1);
  endtask

  task automatic restart_checks(input string tag);
    wait_start(6, {tag, "_start_pulse"});
    chk({tag, "_start_cf"}, int'(count_from), 4);
    for (int i = 0; i < 20 && ph_q.size() == 0; i++) step();
    chk({tag, "_first_tick_phase"}, int'(phase), 1);
    chk({tag, "_first_tick_ns"}, int'(ns_lamp), 1);
    chk({tag, "_first_tick_ew"}, int'(ew_lamp), 4);
  endtask

  int exp_ph[17] = '{1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5, 6, 1};
  int exp_st[7]  = '{4, 1, 0, 4, 1, 0, 4};

  initial begin
    int dis_left;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_start", int'(start), 0);
    chk("rst_cf", int'(count_from), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_ns", int'(ns_lamp), 4);
    chk("rst_ew", int'(ew_lamp), 4);

    release_rst();
    restart_checks("s1");

    for (int i = 0; i < 400 && ph_q.size() < 40; i++) step();
    chk("run_ticks", (ph_q.size() >= 40) ? 1 : 0, 1);
    for (int i = 0; i < 17; i++)
      chk($sformatf("run_phase%0d", i), (i < ph_q.size()) ? ph_q[i] : -1, exp_ph[i]);
    for (int i = 0; i < 7; i++)
      chk($sformatf("run_start%0d", i), (i < starts.size()) ? starts[i] : -1, exp_st[i]);

    wait_phase(1, 200, "s3_reach_ns_g");
    repeat (16) step();
    night = 1'b1;
    wait_phase(7, 400, "s3_reach_flash");
    chk("s3_pre_flash", prev_ph, 3);
    chk("s3_entry_ns", int'(ns_lamp), 0);
    chk("s3_entry_ew", int'(ew_lamp), 0);
    wait_start(4, "s3_flash_start");
    chk("s3_flash_cf", int'(count_from), 0);
    next_tick();
    chk("s3_blink1_ns", int'(ns_lamp), 2);
    chk("s3_blink1_ew", int'(ew_lamp), 2);
    next_tick();
    chk("s3_blink2_ns", int'(ns_lamp), 0);
    next_tick();
    chk("s3_blink3_ns", int'(ns_lamp), 2);

    night = 1'b0;
    for (int i = 0; i < 40 && int'(phase) == 7; i++) step();
    chk("s4_leave_flash", int'(phase), 6);
    wait_start(4, "s4_start");
    chk("s4_cf", int'(count_from), 4);
    wait_phase(1, 40, "s4_ns_g");

    enable = 1'b0;
    repeat (20) step();
    enable = 1'b1;
    step();
    chk("s5_restart", int'(start), 1);
    chk("s5_cf", int'(count_from), 1);
    chk("s5_frozen", int'(phase), 1);

    wait_phase(4, 400, "s6_reach_ew_g");
    repeat (2) step();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_async_phase", int'(phase), 0);
    chk("s6_async_ns", int'(ns_lamp), 4);
    chk("s6_async_ew", int'(ew_lamp), 4);
    chk("s6_async_start", int'(start), 0);
    repeat (3) step();
    release_rst();
    restart_checks("s6");

    dis_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) night = !night;
      if (dis_left > 0) begin
        dis_left--;
        if (dis_left == 0) enable = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        dis_left = $urandom_range(1, 20);
      end
      step();
    end
    enable = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
